cdb_arbiter: RTL
================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's functional units. Each cycle it picks at most one requesting unit and broadcasts that unit's ROB tag and result on a registered CDB. The CDB feeds the register result status table, the reservation stations and the ROB. Bit 3 of the CDB is the broadcast-valid bit and bits 2:0 are the ROB index, so every CDB consumer decodes it unchanged.

## Interface
Parameters:
- N, 4, number of requesting functional units (2..8)
- DW, 32, result data width

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  asynchronous, active-high reset
- Flush  input  1  misprediction flush; drops the current arbitration
- req  input  N  request from unit i; held until granted
- tag  input  3N  ROB index of unit i at bits [3i+2:3i]
- data  input  DW·N  result of unit i at bits [DW·i+DW-1:DW·i]
- grant  output  N  one-hot combinational acknowledge to unit i
- CDB  output  DW+4  registered broadcast: [3] valid, [2:0] ROB tag, [DW+3:4] data
- ptr  output  ⌈log2 N⌉  current round-robin priority pointer (debug)

## Operation
- State:
  - round-robin pointer `ptr`, the index with highest priority this cycle
  - CDB output register
- Arbitration is combinational in each cycle:
  - search req starting at ptr, ascending, wrapping modulo N
  - the first asserted index w gets grant[w]=1; all other grant bits are 0
- With Flush=1 or Reset=1, grant=0 regardless of req.
- When a grant to w occurs, the next edge loads:
  - CDB[3]=1
  - CDB[2:0]=tag[3w+2:3w]
  - CDB data=data[w]
  - ptr ← (w+1) mod N
- With no grant (no req, or Flush), the next edge sets CDB[3]=0 and keeps ptr.
  - CDB tag/data bits are don't-care but are held; the bench checks only the valid bit.
- Requester protocol:
  - a unit keeps req and its tag/data stable until it sees grant high in a cycle
  - it may drop req, or present a new result, in the following cycle
  - dropping req without a grant is allowed only during Flush
- Each grant produces exactly one CDB broadcast; results are never duplicated or lost.
- Fairness: with all N units requesting continuously, each unit is granted exactly once every N cycles.

## Timing
- Reset values: CDB=0 (valid 0), ptr=0, grant=0.
- Latency: grant in cycle t, then CDB valid for exactly the single cycle t+1.
- Throughput is one broadcast per cycle, back-to-back from different units or from the same unit.
- Flush in cycle t:
  - no grant in t
  - CDB valid = 0 in t+1
  - a broadcast already on the CDB in cycle t still completes
- Reset asserted mid-operation:
  - CDB valid clears immediately (asynchronous)
  - the pending grant is discarded
  - ptr=0
- ptr wrap: a grant to N-1 sets ptr=0.
- A single requester is granted in the same cycle it asserts req, whatever ptr is.

## Configuration
- Macro `CDB_ARB_FIXED_PRIO_EN`:
  - defined: fixed priority; the lowest asserted index wins; ptr is held at 0 and never updates
  - undefined: round-robin as specified above
- The Flush, latency and CDB format rules are identical in both builds.

## Test plan
- Reset then idle: Reset=1, req=4'b1111, so grant=0 and CDB=0. After release with req=0, CDB[3] stays 0 and ptr=0.
- Single request:
  - stimulus: req=4'b0100, tag2=3'd5, data2=32'hDEADBEEF
  - grant=4'b0100 the same cycle
  - next cycle CDB[3]=1, CDB[2:0]=5, data=DEADBEEF
  - ptr=3
- Round-robin fairness:
  - stimulus: req=4'b1111 held 8 cycles, each unit re-asserting after its grant
  - grants are 0,1,2,3,0,1,2,3
  - CDB tags match each granted unit, one per cycle
- Flush:
  - stimulus: req=4'b0011 with Flush=1 in cycle t
  - grant=0 in t and CDB[3]=0 in t+1
  - Flush=0 in t+1 gives a grant to unit ptr (0)
- Mid-operation reset: Reset pulsed while CDB[3]=1 and ptr=2, so CDB=0 and ptr=0 without waiting for a clock edge.
- Fixed-priority build: with `CDB_ARB_FIXED_PRIO_EN` defined and req=4'b1010 held, unit 1 is granted every cycle and unit 3 never.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ----------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the functional-unit request side and the common data bus (CDB)
// broadcast side of the CDB arbiter.
//
// Parameters:
//   N   number of requesting functional units (2..8)
//   DW  result data width
//
// Signals:
//   req    [N-1:0]       request from unit i, held until granted
//   tag    [3N-1:0]      ROB index of unit i at [3i+2:3i]
//   data   [DW*N-1:0]    result of unit i at [DW*i+DW-1:DW*i]
//   grant  [N-1:0]       one-hot combinational acknowledge
//   CDB    [DW+3:0]      registered broadcast: [3] valid, [2:0] tag, [DW+3:4] data
//   ptr    [PW-1:0]      round-robin priority pointer (debug)
//
// Modports:
//   master  functional-unit side (drives req/tag/data)
//   slave   arbiter side (drives grant/CDB/ptr)
// ----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    localparam int PW = $clog2(N);

    logic [N-1:0]    req;
    logic [3*N-1:0]  tag;
    logic [DW*N-1:0] data;
    logic [N-1:0]    grant;
    logic [DW+3:0]   CDB;
    logic [PW-1:0]   ptr;

    modport master (output req, tag, data, input grant, CDB, ptr);
    modport slave  (input req, tag, data, output grant, CDB, ptr);
endinterface

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus among the out-of-order core's functional
// units. Each cycle at most one requester is granted (round-robin from ptr)
// and its ROB tag and result are broadcast on the registered CDB one cycle
// later.
//
// Parameters:
//   N   number of requesting functional units (2..8)
//   DW  result data width
//
// Ports:
//   CLK    clock, rising edge
//   Reset  asynchronous, active-high reset
//   Flush  misprediction flush; suppresses the grant of the current cycle
//   bus    cdb_arbiter_if.slave: req/tag/data in, grant/CDB/ptr out
//
// Build option:
//   CDB_ARB_FIXED_PRIO_EN  when defined, the lowest asserted index always wins
//                          and ptr stays at 0; otherwise round-robin.
// ----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int N  = 4,
    parameter int DW = 32
) (
    input  logic CLK,
    input  logic Reset,
    input  logic Flush,
    cdb_arbiter_if.slave bus
);
    localparam int           PW = $clog2(N);
    localparam logic [PW:0]  NW = (PW+1)'(N);

    logic [PW-1:0] r_ptr;
    logic [DW+3:0] r_cdb;

    logic [PW-1:0] w_base;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_win;
    logic          w_found;
    logic          w_any;
    logic [N-1:0]  w_grant;
    logic [2:0]    w_sel_tag;
    logic [DW-1:0] w_sel_data;
    logic [PW-1:0] w_ptr_nxt;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // Search always starts at unit 0, so the lowest requester wins.
    assign w_base    = '0;
    assign w_ptr_nxt = '0;
`else
    assign w_base    = r_ptr;
    assign w_ptr_nxt = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
`endif

    // Scan requesters starting at w_base, wrapping modulo N; first hit wins.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, w_base} + (PW+1)'(k);
            if (w_sum >= NW) w_sum = w_sum - NW;
            if (!w_found && bus.req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    // Reset and Flush both veto the grant combinationally.
    assign w_any = w_found && !Flush && !Reset;

    always_comb begin
        w_grant    = '0;
        w_sel_tag  = '0;
        w_sel_data = '0;
        if (w_any) w_grant[w_win] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (w_win == PW'(i)) begin
                w_sel_tag  = bus.tag[3*i +: 3];
                w_sel_data = bus.data[DW*i +: DW];
            end
        end
    end

    // Without a grant only the valid bit drops; tag/data are held.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_cdb <= '0;
            r_ptr <= '0;
        end else if (w_any) begin
            r_cdb <= {w_sel_data, 1'b1, w_sel_tag};
            r_ptr <= w_ptr_nxt;
        end else begin
            r_cdb[3] <= 1'b0;
        end
    end

    assign bus.grant = w_grant;
    assign bus.CDB   = r_cdb;
    assign bus.ptr   = r_ptr;
endmodule
